// File: rtl/psc_trigger_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : psc_trigger_receiver_if
// Description : Serial line input and packet-status outputs of the PSC
//               trigger receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface psc_trigger_receiver_if;
    logic        rx_in;
    logic        trigger_pulse;
    logic        pkt_valid;
    logic [7:0]  pkt_type;
    logic [7:0]  pkt_arg;
    logic        crc_error;
    logic        frame_error;
    logic [15:0] error_count;

    // master drives the line and observes status; slave is the receiver
    modport master (
        output rx_in,
        input  trigger_pulse, pkt_valid, pkt_type, pkt_arg,
        input  crc_error, frame_error, error_count
    );

    modport slave (
        input  rx_in,
        output trigger_pulse, pkt_valid, pkt_type, pkt_arg,
        output crc_error, frame_error, error_count
    );
endinterface
`default_nettype wire

// File: rtl/psc_trigger_receiver.sv
`default_nettype none
// ============================================================================
// Module      : psc_trigger_receiver
// Description : PSC trigger link receiver: deframes 10-bit words, assembles
//               fixed-length packets, checks CRC-8 and flags triggers.
// Revision    : 1.0 - initial release
// ============================================================================
module psc_trigger_receiver #(
    parameter int         CLKS_PER_BIT = 5,
    parameter int         PKT_LEN      = 4,
    parameter int         IDLE_GAP     = 100,
    parameter logic [7:0] SYNC_BYTE    = 8'h55,
    parameter logic [7:0] TRIG_TYPE    = 8'h01
) (
    input wire                    clk,
    input wire                    reset,
    psc_trigger_receiver_if.slave bus
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_GAP_W = $clog2(IDLE_GAP + 1);
    localparam int c_IDX_W = 4;

    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(IDLE_GAP);
    localparam logic [c_GAP_W-1:0] c_GAP_PRE = c_GAP_W'(IDLE_GAP - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } bit_state_t;

    typedef enum logic [1:0] {
        PK_HUNT = 2'd0,
        PK_RECV = 2'd1,
        PK_WAIT = 2'd2
    } pkt_state_t;

    // MSB-first CRC-8, polynomial 0x07
    function automatic logic [7:0] crc8_step(input logic [7:0] crc_in,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Line synchronizer and edge history
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_s;
    logic r_rx_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= bus.rx_in;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Bit FSM
    // ------------------------------------------------------------------
    bit_state_t         r_bit_state;
    bit_state_t         w_bit_state_nxt;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_CNT_W-1:0] w_bit_cnt_nxt;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               w_byte_ok;
    logic               w_byte_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_state <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
        end else begin
            r_bit_state <= w_bit_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
        end
    end

    always_comb begin
        w_bit_state_nxt = r_bit_state;
        w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_byte_ok       = 1'b0;
        w_byte_bad      = 1'b0;
        case (r_bit_state)
            ST_IDLE: begin
                w_bit_cnt_nxt = '0;
                if (r_rx_prev && !r_rx_s) begin
                    w_bit_state_nxt = ST_START;
                end
            end
            ST_START: begin
                // a line that is high again at mid-start-bit was only a glitch
                if (r_bit_cnt == c_HALF_M1) begin
                    w_bit_cnt_nxt   = '0;
                    w_bit_idx_nxt   = '0;
                    w_bit_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_bit_cnt == c_FULL_M1) begin
                    w_bit_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_s, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_bit_state_nxt = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (r_bit_cnt == c_FULL_M1) begin
                    w_bit_cnt_nxt   = '0;
                    w_bit_state_nxt = ST_IDLE;
                    w_byte_ok       = r_rx_s;
                    w_byte_bad      = !r_rx_s;
                end
            end
            default: begin
                w_bit_cnt_nxt   = '0;
                w_bit_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Idle-gap detector; w_gap_hit fires once on the cycle the gap is reached
    // ------------------------------------------------------------------
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_cnt_nxt;
    logic               w_gap_hit;

    always_comb begin
        w_gap_cnt_nxt = '0;
        w_gap_hit     = 1'b0;
        if (r_bit_state == ST_IDLE && r_rx_s) begin
            w_gap_cnt_nxt = r_gap_cnt;
            if (r_gap_cnt != c_GAP_MAX) begin
                w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                w_gap_hit     = (r_gap_cnt == c_GAP_PRE);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap_cnt <= '0;
        end else begin
            r_gap_cnt <= w_gap_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    pkt_state_t         r_pkt_state;
    pkt_state_t         w_pkt_state_nxt;
    logic [c_IDX_W-1:0] r_byte_idx;
    logic [c_IDX_W-1:0] w_byte_idx_nxt;
    logic [7:0]         r_crc;
    logic [7:0]         w_crc_nxt;
    logic [7:0]         r_type_buf;
    logic [7:0]         w_type_buf_nxt;
    logic [7:0]         r_arg_buf;
    logic [7:0]         w_arg_buf_nxt;
    logic               w_valid;
    logic               w_trig;
    logic               w_crc_err;
    logic               w_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_state <= PK_HUNT;
            r_byte_idx  <= '0;
            r_crc       <= '0;
            r_type_buf  <= '0;
            r_arg_buf   <= '0;
        end else begin
            r_pkt_state <= w_pkt_state_nxt;
            r_byte_idx  <= w_byte_idx_nxt;
            r_crc       <= w_crc_nxt;
            r_type_buf  <= w_type_buf_nxt;
            r_arg_buf   <= w_arg_buf_nxt;
        end
    end

    always_comb begin
        w_pkt_state_nxt = r_pkt_state;
        w_byte_idx_nxt  = r_byte_idx;
        w_crc_nxt       = r_crc;
        w_type_buf_nxt  = r_type_buf;
        w_arg_buf_nxt   = r_arg_buf;
        w_valid         = 1'b0;
        w_trig          = 1'b0;
        w_crc_err       = 1'b0;
        w_frame_err     = 1'b0;
        case (r_pkt_state)
            PK_RECV: begin
                if (w_byte_bad) begin
                    w_frame_err     = 1'b1;
                    w_pkt_state_nxt = PK_HUNT;
                end else if (w_byte_ok) begin
                    if (r_byte_idx == '0 && r_shift != SYNC_BYTE) begin
                        w_frame_err     = 1'b1;
                        w_pkt_state_nxt = PK_HUNT;
                    end else if (r_byte_idx == c_LAST_IDX) begin
                        // the CRC register already covers bytes 0..PKT_LEN-2
                        if (r_shift == r_crc) begin
                            w_valid = 1'b1;
                            w_trig  = (r_type_buf == TRIG_TYPE);
                        end else begin
                            w_crc_err = 1'b1;
                        end
                        w_pkt_state_nxt = PK_WAIT;
                    end else begin
                        w_crc_nxt      = crc8_step(r_crc, r_shift);
                        w_byte_idx_nxt = r_byte_idx + 4'd1;
                        if (r_byte_idx == 4'd1) begin
                            w_type_buf_nxt = r_shift;
                        end
                        if (r_byte_idx == 4'd2) begin
                            w_arg_buf_nxt = r_shift;
                        end
                    end
                end else if (w_gap_hit && r_byte_idx != '0) begin
                    w_frame_err = 1'b1;
                end
            end
            PK_WAIT: begin
                if (w_byte_ok || w_byte_bad) begin
                    w_frame_err     = 1'b1;
                    w_pkt_state_nxt = PK_HUNT;
                end
            end
            default: begin
            end
        endcase
        // a completed idle gap always rearms packet assembly
        if (w_gap_hit) begin
            w_pkt_state_nxt = PK_RECV;
            w_byte_idx_nxt  = '0;
            w_crc_nxt       = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.trigger_pulse <= 1'b0;
            bus.pkt_valid     <= 1'b0;
            bus.crc_error     <= 1'b0;
            bus.frame_error   <= 1'b0;
            bus.pkt_type      <= 8'h00;
            bus.pkt_arg       <= 8'h00;
            bus.error_count   <= 16'h0000;
        end else begin
            bus.trigger_pulse <= w_trig;
            bus.pkt_valid     <= w_valid;
            bus.crc_error     <= w_crc_err;
            bus.frame_error   <= w_frame_err;
            if (w_valid) begin
                bus.pkt_type <= r_type_buf;
                bus.pkt_arg  <= r_arg_buf;
            end
            if ((w_crc_err || w_frame_err) && bus.error_count != 16'hFFFF) begin
                bus.error_count <= bus.error_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/psc_trigger_receiver.md
# psc_trigger_receiver

Serial receiver for the PSC trigger link: takes the single-wire 10 Mb/s stream driven on `psc_output` and reconstructs packets. Deframes 10-bit words, assembles fixed-length packets and checks the trailing CRC-8. Emits a one-cycle `trigger_pulse` when a valid trigger packet arrives. Sits at the power-supply-controller end of the link, directly downstream of the trigger transmitter, and serves as that path's loopback checker in the test build.

## Interface
- `CLKS_PER_BIT`, 5, `clk` cycles per line bit (50 MHz / 10 Mb/s); minimum 4
- `PKT_LEN`, 4, bytes per packet including CRC; minimum 4, maximum 16
- `IDLE_GAP`, 100, consecutive idle-high `clk` cycles that delimit packets
- `SYNC_BYTE`, 8'h55, required value of byte 0
- `TRIG_TYPE`, 8'h01, byte-1 value identifying a trigger packet
- `clk` in 1: 50 MHz system clock
- `reset` in 1: one clock; reset is synchronous and active-high
- `rx_in` in 1: serial line, asynchronous to `clk`, idles high
- `trigger_pulse` out 1: one-cycle pulse on a valid packet whose type is `TRIG_TYPE`
- `pkt_valid` out 1: one-cycle pulse on any valid packet
- `pkt_type` out 8: byte 1 of the last valid packet; held until the next one
- `pkt_arg` out 8: byte 2 of the last valid packet; held until the next one
- `crc_error` out 1: one-cycle pulse when a complete packet fails CRC
- `frame_error` out 1: one-cycle pulse on a bad stop bit, bad sync byte, or wrong packet length
- `error_count` out 16: count of `crc_error` plus `frame_error` pulses; saturates at 16'hFFFF

## Operation
- `rx_in` passes through a 2-FF synchronizer. All logic uses the synchronized value `rx_s`.
- Word format is 10 bits: start bit (0), 8 data bits LSB first, stop bit (1). Words may be back-to-back with no idle bits between them.
- Bit FSM states and transitions:
  - IDLE: a falling edge of `rx_s` goes to START.
  - START: after `CLKS_PER_BIT/2` cycles, sample the line. If 0, go to DATA; if 1, treat as a glitch and return to IDLE with no error.
  - DATA: sample every `CLKS_PER_BIT` cycles; 8 samples are shifted in LSB first, then go to STOP.
  - STOP: sample `CLKS_PER_BIT` cycles later. If 1, the byte is good; if 0, raise `frame_error`. Either way return to IDLE on the same cycle, so an immediately following start edge is caught.
- Packet layer keeps a byte index `0..PKT_LEN-1` and a running CRC-8.
  - CRC polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - CRC is computed over bytes `0..PKT_LEN-2` and compared against byte `PKT_LEN-1`.
  - Byte 0 must equal `SYNC_BYTE`; otherwise raise `frame_error` and enter HUNT.
  - On the last byte: CRC match gives `pkt_valid`, updates `pkt_type`/`pkt_arg`, and gives `trigger_pulse` if the type is `TRIG_TYPE`. A mismatch gives `crc_error`. Either way the packet layer then waits for the idle gap.
- Idle-gap counter counts consecutive `rx_s`=1 cycles while the bit FSM is in IDLE and saturates at `IDLE_GAP`. Reaching `IDLE_GAP` resets the byte index and CRC to 0 and leaves HUNT.
- Gap reached with byte index in 1..`PKT_LEN-1`: short packet; raise `frame_error` and discard it.
- Byte received after a complete packet but before the gap: raise `frame_error` and enter HUNT.
- Framing error mid-packet: discard the partial packet and enter HUNT.
- In HUNT, the bit FSM keeps running but bytes are ignored and produce no further errors until the gap.
- Simultaneous `crc_error` and `frame_error` in the same cycle increment `error_count` by 1.

## Timing
- Reset values: `trigger_pulse`, `pkt_valid`, `crc_error`, `frame_error` = 0; `pkt_type`, `pkt_arg` = 8'h00; `error_count` = 0.
- After reset, the block is in HUNT and requires `IDLE_GAP` idle cycles before accepting a packet.
- Reset mid-word or mid-packet: the partial packet is discarded silently, with no error pulse.
- All outputs are registered. Pulses assert exactly 1 `clk` after the stop-bit sample of the final byte.
- End-to-end latency: `rx_in` start edge of the last word to `trigger_pulse` is 2 (sync) + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` + 1 cycles, which is 50 cycles at defaults.
- Tolerates ±2% bit-rate mismatch at `CLKS_PER_BIT`=5.

## Test plan
- Reset, 100 idle cycles, then packet 55 01 00 F1 back-to-back at 5 clk/bit -> one `trigger_pulse`, `pkt_valid`=1, `pkt_type`=01, `pkt_arg`=00, `error_count`=0.
- Packet 55 01 00 F0 (bad CRC) -> `crc_error` pulse, no `trigger_pulse`, `pkt_type` keeps its previous value, `error_count`=1.
- Stop bit forced 0 in byte 2, then 100 idle cycles, then a good packet -> one `frame_error` pulse only, followed by a normal `trigger_pulse`.
- 55 01 followed by 100 idle cycles -> `frame_error` (short packet); then 55 02 00 with correct CRC -> `pkt_valid` with `pkt_type`=02 and no `trigger_pulse`.
- 1-cycle low glitch on idle line -> no outputs. `reset` asserted during byte 2 of a packet, then a good packet sent after the gap -> only the second packet is reported.
- Force 65536 CRC errors -> `error_count` holds 16'hFFFF.
